// File: rtl/aim_line_draw_pkg.sv
// Shared definitions for the aim-line redraw block: grid size, origin, widths and FSM states.
package aim_line_draw_pkg;

  localparam int unsigned XW = 8;   // x coordinate width
  localparam int unsigned YW = 7;   // y coordinate width
  localparam int unsigned CW = 3;   // colour width
  localparam int unsigned EW = 10;  // signed delta / error width

  localparam int unsigned    SCREEN_W_DEF = 160;
  localparam int unsigned    SCREEN_H_DEF = 120;
  localparam logic [XW-1:0]  ORIGIN_X_DEF = 8'd60;
  localparam logic [YW-1:0]  ORIGIN_Y_DEF = 7'd64;

  typedef enum logic [2:0] {
    StIdle,
    StEraseInit,
    StErase,
    StDrawInit,
    StDraw,
    StDone
  } state_e;

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v, input logic [XW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v, input logic [YW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/aim_line_draw_line_stepper.sv
// Integer Bresenham line stepper, valid in all eight octants.
// load captures the endpoints; each step advances one pixel until last is reached.
module line_stepper
  import aim_line_draw_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0]        x_q, x_d, xe_q;
  logic [YW-1:0]        y_q, y_d, ye_q;
  logic signed [EW-1:0] dx_q, dy_q, err_q, err_d;
  logic signed [EW-1:0] ddx, ddy, adx, ady, e2;
  logic                 sx_q, sy_q;

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xe_q) && (y_q == ye_q);

  always_comb begin
    ddx   = $signed(EW'(x1)) - $signed(EW'(x0));
    ddy   = $signed(EW'(y1)) - $signed(EW'(y0));
    adx   = ddx[EW-1] ? -ddx : ddx;
    ady   = ddy[EW-1] ? -ddy : ddy;
    e2    = err_q <<< 1;
    x_d   = x_q;
    y_d   = y_q;
    err_d = err_q;
    if (step && !last) begin
      // dy_q is kept non-positive so one error term serves both axes
      if (e2 >= dy_q) begin
        err_d = err_d + dy_q;
        x_d   = sx_q ? x_q - XW'(1) : x_q + XW'(1);
      end
      if (e2 <= dx_q) begin
        err_d = err_d + dx_q;
        y_d   = sy_q ? y_q - YW'(1) : y_q + YW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q   <= '0;
      y_q   <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      err_q <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
    end else if (load) begin
      x_q   <= x0;
      y_q   <= y0;
      xe_q  <= x1;
      ye_q  <= y1;
      dx_q  <= adx;
      dy_q  <= -ady;
      err_q <= adx - ady;
      sx_q  <= ddx[EW-1];
      sy_q  <= ddy[EW-1];
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/aim_line_draw.sv
// Aim-line redraw: erases the previous line in black, then draws the new line,
// both from the fixed origin, one pixel per cycle through a shared stepper.
module aim_line_draw
  import aim_line_draw_pkg::*;
#(
  parameter logic [XW-1:0] ORIGIN_X = ORIGIN_X_DEF,
  parameter logic [YW-1:0] ORIGIN_Y = ORIGIN_Y_DEF,
  parameter int unsigned   SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned   SCREEN_H = SCREEN_H_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x_end,
  input  logic [YW-1:0] y_end,
  input  logic [CW-1:0] color_in,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_color,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  localparam logic [XW-1:0] XMax = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] YMax = YW'(SCREEN_H - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] tx_q, px_q, vx_q, st_x, ld_x;
  logic [YW-1:0] ty_q, py_q, vy_q, st_y, ld_y;
  logic [CW-1:0] col_q, vc_q, cur_color;
  logic          accept, store_prev, ld, stp, st_last;

  line_stepper u_stepper (
    .clk    (clk),
    .resetn (resetn),
    .load   (ld),
    .step   (stp),
    .x0     (ORIGIN_X),
    .y0     (ORIGIN_Y),
    .x1     (ld_x),
    .y1     (ld_y),
    .x      (st_x),
    .y      (st_y),
    .last   (st_last)
  );

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    store_prev = 1'b0;
    ld         = 1'b0;
    stp        = 1'b0;
    plot       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    cur_color  = col_q;
    ld_x       = px_q;
    ld_y       = py_q;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_d = StEraseInit;
        end
      end
      StEraseInit: begin
        ld      = 1'b1;
        state_d = StErase;
      end
      StErase: begin
        plot      = 1'b1;
        cur_color = '0;
        if (st_last) state_d = StDrawInit;
        else         stp     = 1'b1;
      end
      StDrawInit: begin
        ld      = 1'b1;
        ld_x    = tx_q;
        ld_y    = ty_q;
        state_d = StDraw;
      end
      StDraw: begin
        plot = 1'b1;
        if (st_last) begin
          store_prev = 1'b1;
          state_d    = StDone;
        end else begin
          stp = 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Pixel outputs pass through while plotting and hold otherwise
  assign vga_x     = plot ? st_x : vx_q;
  assign vga_y     = plot ? st_y : vy_q;
  assign vga_color = plot ? cur_color : vc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      tx_q    <= ORIGIN_X;
      ty_q    <= ORIGIN_Y;
      px_q    <= ORIGIN_X;
      py_q    <= ORIGIN_Y;
      col_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tx_q  <= clamp_x(x_end, XMax);
        ty_q  <= clamp_y(y_end, YMax);
        col_q <= color_in;
      end
      if (store_prev) begin
        px_q <= tx_q;
        py_q <= ty_q;
      end
      if (plot) begin
        vx_q <= st_x;
        vy_q <= st_y;
        vc_q <= cur_color;
      end
    end
  end

endmodule

// File: doc/aim_line_draw.md
AIM_LINE_DRAW -- requirements
Module: aim_line_draw

Interface
REQ-001 Parameter ORIGIN_X, 8'd60, fixed x of the aim-line start pixel.
REQ-002 Parameter ORIGIN_Y, 7'd64, fixed y of the aim-line start pixel.
REQ-003 Parameter SCREEN_W, 160 and SCREEN_H, 120 SHALL set the visible grid; x_end and y_end are clamped to W-1 and H-1.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 start  input  1  request to redraw the aim line; level sampled each cycle.
REQ-007 x_end  input  8  aim-line end x from the angle-select stage.
REQ-008 y_end  input  7  aim-line end y from the angle-select stage.
REQ-009 color_in  input  3  draw colour for the new line.
REQ-010 vga_x  output  8  pixel x to the VGA adapter.
REQ-011 vga_y  output  7  pixel y to the VGA adapter.
REQ-012 vga_color  output  3  pixel colour to the VGA adapter.
REQ-013 plot  output  1  write strobe; one pixel per high cycle.
REQ-014 busy  output  1  high from request acceptance until done.
REQ-015 done  output  1  one-cycle pulse when the redraw completes.

Function
REQ-016 FSM states: IDLE, ERASE_INIT, ERASE, DRAW_INIT, DRAW, DONE.
REQ-017 IDLE: start=1 SHALL latch the clamped x_end/y_end and color_in, then go to ERASE_INIT next cycle with busy=1.
REQ-018 start SHALL be ignored in every state other than IDLE; the latched values SHALL NOT change while busy.
REQ-019 ERASE_INIT: load the stepper with (ORIGIN_X,ORIGIN_Y) -> stored previous endpoint; plot=0.
REQ-020 ERASE: one pixel per cycle with plot=1, vga_color=3'b000; after the last pixel go to DRAW_INIT.
REQ-021 DRAW_INIT: load the stepper with origin -> latched endpoint; plot=0.
REQ-022 DRAW: one pixel per cycle with plot=1, vga_color=latched colour; after the last pixel store the latched endpoint as the previous endpoint and go to DONE.
REQ-023 DONE: done=1, busy=1, plot=0 for one cycle, then IDLE with busy=0.
REQ-024 Line generation SHALL be integer Bresenham valid in all eight octants, stepping the major axis by exactly 1 per pixel; the pixel count is max(|dx|,|dy|)+1, first pixel = origin, last pixel = endpoint exactly.
REQ-025 Error term and deltas SHALL be signed with width 10 bits so no overflow occurs for any on-screen endpoint.
REQ-026 An endpoint equal to the origin SHALL produce exactly one pixel (the origin) in that phase.
REQ-027 Total redraw latency from start acceptance = 2 + Nerase + 1 + Ndraw + 1 cycles to done; plot cycles = Nerase + Ndraw.
REQ-028 When plot=0, vga_x/vga_y/vga_color SHALL hold their last values.

Reset
REQ-029 resetn=0 SHALL asynchronously force state IDLE, plot=0, busy=0, done=0, vga_x=0, vga_y=0, vga_color=0.
REQ-030 Reset SHALL set the stored previous endpoint to (ORIGIN_X,ORIGIN_Y) and the latched colour to 0.
REQ-031 Reset asserted mid-ERASE or mid-DRAW SHALL abort with no further plot pulse after release until a new start.

Structure
REQ-032 Shared header: screen dimensions, origin defaults, FSM state encodings, and coordinate widths.
REQ-033 One sub-module, line_stepper: load/step/last interface holding the Bresenham position and error; instantiated once, shared by the erase and draw phases.

Verification
REQ-034 After reset, start with (60,64), colour 3'b111 -> erase pixel (60,64) in colour 0, draw pixel (60,64) in colour 7; 2 plot pulses; done 6 cycles after acceptance.
REQ-035 Start with (42,46), colour 3'b100 -> 1 erase pixel at origin, then 19 draw pixels (60,64),(59,63)...(42,46); done after 24 cycles.
REQ-036 Follow-up start with (50,64) -> the 19 prior pixels are re-plotted in colour 0, then 11 pixels (60,64)...(50,64) horizontal; the previous endpoint becomes (50,64).
REQ-037 start held high for the whole of REQ-035 with the inputs changed mid-draw -> exactly one redraw using the values latched at acceptance, then a new acceptance only after returning to IDLE.
REQ-038 x_end=200, y_end=127 -> clamped endpoint (159,119); the last drawn pixel is exactly (159,119).
REQ-039 resetn pulsed low during DRAW -> outputs are zero immediately; no plot after release; the next start erases from origin only (1 pixel).
